// File: rtl/mm_stream_ctrl.sv
// mm_stream_ctrl: AXI-Stream front/back end for the mm_new matrix engine.
//   Loads A (M x N) then B (N x P) row-major from the slave stream into the
//   A/B RAM write ports, drives the engine Start/Done handshake, then reads
//   the M x P result RAM and emits it on the master stream with TLAST on the
//   final word.
// Ports:
//   clk, resetn            - clock, asynchronous active-low reset
//   S_AXIS_*               - input stream (TLAST ignored, upper TDATA dropped)
//   M_AXIS_*               - output stream
//   A_write_*, B_write_*   - A/B RAM write ports (one cycle per word)
//   Start / Done           - engine request (level) / completion
//   RES_read_*             - RES RAM read port, 1-cycle read latency
//   compute_cycles         - engine run length
// Optional feature: define MM_STREAM_PERF_CNT_EN to build the run-length
// counter behind compute_cycles; otherwise compute_cycles is tied to 0.
module mm_stream_ctrl #(
  parameter int width          = 8,
  parameter int A_depth_bits   = 9,
  parameter int B_depth_bits   = 9,
  parameter int RES_depth_bits = 9,
  parameter int M              = 64,
  parameter int N              = 8,
  parameter int P              = 4,
  parameter int AXIS_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      S_AXIS_TVALID,
  output logic                      S_AXIS_TREADY,
  input  logic [AXIS_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic                      S_AXIS_TLAST,
  output logic                      M_AXIS_TVALID,
  input  logic                      M_AXIS_TREADY,
  output logic [AXIS_WIDTH-1:0]     M_AXIS_TDATA,
  output logic                      M_AXIS_TLAST,
  output logic                      A_write_en,
  output logic [A_depth_bits-1:0]   A_write_address,
  output logic [width-1:0]          A_write_data_in,
  output logic                      B_write_en,
  output logic [B_depth_bits-1:0]   B_write_address,
  output logic [width-1:0]          B_write_data_in,
  output logic                      Start,
  input  logic                      Done,
  output logic                      RES_read_en,
  output logic [RES_depth_bits-1:0] RES_read_address,
  input  logic [width-1:0]          RES_read_data_out,
  output logic [31:0]               compute_cycles
);

  localparam logic [31:0] A_LAST = 32'(M * N - 1);
  localparam logic [31:0] B_LAST = 32'(N * P - 1);
  localparam logic [31:0] R_LAST = 32'(M * P - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RECV_A   = 3'd1;
  localparam logic [2:0] S_RECV_B   = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;
  localparam logic [2:0] S_RD_ISSUE = 3'd5;
  localparam logic [2:0] S_RD_WAIT  = 3'd6;
  localparam logic [2:0] S_SEND     = 3'd7;

  logic [2:0]                r_state;
  logic [31:0]               r_cnt;
  logic                      r_tready;
  logic                      r_tvalid;
  logic [AXIS_WIDTH-1:0]     r_tdata;
  logic                      r_tlast;
  logic                      r_a_we;
  logic [A_depth_bits-1:0]   r_a_addr;
  logic [width-1:0]          r_a_data;
  logic                      r_b_we;
  logic [B_depth_bits-1:0]   r_b_addr;
  logic [width-1:0]          r_b_data;
  logic                      r_start;
  logic                      r_res_re;
  logic [RES_depth_bits-1:0] r_res_addr;

  logic [31:0] w_cnt_nxt;
  logic        w_b_last;
  logic        w_unused;

  assign w_cnt_nxt = r_cnt + 32'd1;
  // Final B handshake: the cycle that commits the move into RUN.
  assign w_b_last  = (r_state == S_RECV_B) && S_AXIS_TVALID && (r_cnt == B_LAST);
  // Frame length is fixed by parameters, so TLAST and the upper data bits are don't-care.
  assign w_unused  = ^{S_AXIS_TLAST, S_AXIS_TDATA[AXIS_WIDTH-1:width]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_tready   <= 1'b0;
      r_tvalid   <= 1'b0;
      r_tdata    <= '0;
      r_tlast    <= 1'b0;
      r_a_we     <= 1'b0;
      r_a_addr   <= '0;
      r_a_data   <= '0;
      r_b_we     <= 1'b0;
      r_b_addr   <= '0;
      r_b_data   <= '0;
      r_start    <= 1'b0;
      r_res_re   <= 1'b0;
      r_res_addr <= '0;
    end else begin
      r_a_we   <= 1'b0;
      r_b_we   <= 1'b0;
      r_res_re <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt    <= '0;
          r_tready <= 1'b1;
          r_state  <= S_RECV_A;
        end
        S_RECV_A: begin
          if (S_AXIS_TVALID) begin
            r_a_we   <= 1'b1;
            r_a_addr <= r_cnt[A_depth_bits-1:0];
            r_a_data <= S_AXIS_TDATA[width-1:0];
            if (r_cnt == A_LAST) begin
              r_cnt   <= '0;
              r_state <= S_RECV_B;
            end else begin
              r_cnt <= w_cnt_nxt;
            end
          end
        end
        S_RECV_B: begin
          if (S_AXIS_TVALID) begin
            r_b_we   <= 1'b1;
            r_b_addr <= r_cnt[B_depth_bits-1:0];
            r_b_data <= S_AXIS_TDATA[width-1:0];
            if (w_b_last) begin
              r_cnt    <= '0;
              r_tready <= 1'b0;
              r_state  <= S_RUN;
            end else begin
              r_cnt <= w_cnt_nxt;
            end
          end
        end
        S_RUN: begin
          // Start must stay high until Done; dropping it restarts the engine.
          if (Done) begin
            r_start <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_start <= 1'b1;
          end
        end
        S_DRAIN: begin
          // Lets the engine's last RES write (same cycle as Done) land first.
          r_res_re   <= 1'b1;
          r_res_addr <= r_cnt[RES_depth_bits-1:0];
          r_state    <= S_RD_ISSUE;
        end
        S_RD_ISSUE: begin
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          r_tvalid <= 1'b1;
          r_tdata  <= AXIS_WIDTH'(RES_read_data_out);
          r_tlast  <= (r_cnt == R_LAST);
          r_state  <= S_SEND;
        end
        S_SEND: begin
          if (M_AXIS_TREADY) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            if (r_tlast) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt      <= w_cnt_nxt;
              r_res_re   <= 1'b1;
              r_res_addr <= w_cnt_nxt[RES_depth_bits-1:0];
              r_state    <= S_RD_ISSUE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MM_STREAM_PERF_CNT_EN
  logic [31:0] r_perf;

  // Counts RUN cycles that do not sample Done; holds its value outside RUN.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_perf <= '0;
    end else if (w_b_last) begin
      r_perf <= '0;
    end else if ((r_state == S_RUN) && !Done) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign compute_cycles = r_perf;
`else
  assign compute_cycles = '0;
`endif

  assign S_AXIS_TREADY    = r_tready;
  assign M_AXIS_TVALID    = r_tvalid;
  assign M_AXIS_TDATA     = r_tdata;
  assign M_AXIS_TLAST     = r_tlast;
  assign A_write_en       = r_a_we;
  assign A_write_address  = r_a_addr;
  assign A_write_data_in  = r_a_data;
  assign B_write_en       = r_b_we;
  assign B_write_address  = r_b_addr;
  assign B_write_data_in  = r_b_data;
  assign Start            = r_start;
  assign RES_read_en      = r_res_re;
  assign RES_read_address = r_res_addr;

endmodule

// File: tb/tb_mm_stream_ctrl.sv
// Self-checking bench for mm_stream_ctrl: random input frames, a behavioural
// RES RAM, an engine modelled by the main sequence, and expected values taken
// from the frame layout (word k -> A[k] or B[k-M*N], result beat r -> RES[r]).
module tb_mm_stream_ctrl;

  localparam int W  = 8;
  localparam int M  = 64;
  localparam int N  = 8;
  localparam int P  = 4;
  localparam int AW = 32;
  localparam int NA = M * N;
  localparam int NB = N * P;
  localparam int NR = M * P;

  logic          clk = 1'b0;
  logic          resetn;
  logic          S_AXIS_TVALID, S_AXIS_TREADY, S_AXIS_TLAST;
  logic [AW-1:0] S_AXIS_TDATA;
  logic          M_AXIS_TVALID, M_AXIS_TREADY, M_AXIS_TLAST;
  logic [AW-1:0] M_AXIS_TDATA;
  logic          A_write_en, B_write_en, Start, Done, RES_read_en;
  logic [8:0]    A_write_address, B_write_address, RES_read_address;
  logic [W-1:0]  A_write_data_in, B_write_data_in, RES_read_data_out;
  logic [31:0]   compute_cycles;

  always #5 clk = ~clk;

  mm_stream_ctrl #(
    .width(W), .A_depth_bits(9), .B_depth_bits(9), .RES_depth_bits(9),
    .M(M), .N(N), .P(P), .AXIS_WIDTH(AW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TLAST(S_AXIS_TLAST),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TLAST(M_AXIS_TLAST),
    .A_write_en(A_write_en), .A_write_address(A_write_address),
    .A_write_data_in(A_write_data_in),
    .B_write_en(B_write_en), .B_write_address(B_write_address),
    .B_write_data_in(B_write_data_in),
    .Start(Start), .Done(Done),
    .RES_read_en(RES_read_en), .RES_read_address(RES_read_address),
    .RES_read_data_out(RES_read_data_out),
    .compute_cycles(compute_cycles)
  );

  // Result RAM: synchronous read, one cycle latency.
  logic [W-1:0] res_mem [0:511];
  logic [W-1:0] res_q;
  always @(posedge clk) if (RES_read_en) res_q <= res_mem[RES_read_address];
  assign RES_read_data_out = res_q;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Write-port model: an accepted word with frame index k must appear as a
  // single-cycle write in the following cycle, A[k] or B[k-NA].
  bit          pend;
  int          pend_idx;
  logic [31:0] pend_dat;
  int          acc_cnt;
  always @(negedge clk) begin
    if (!resetn) begin
      pend    = 1'b0;
      acc_cnt = 0;
    end else begin
      if (pend) begin
        if (pend_idx < NA) begin
          chk("a_we",   64'(A_write_en), 64'(1));
          chk("a_addr", 64'(A_write_address), 64'(pend_idx));
          chk("a_data", 64'(A_write_data_in), 64'(pend_dat[7:0]));
          chk("b_we_off", 64'(B_write_en), 64'(0));
        end else begin
          chk("b_we",   64'(B_write_en), 64'(1));
          chk("b_addr", 64'(B_write_address), 64'(pend_idx - NA));
          chk("b_data", 64'(B_write_data_in), 64'(pend_dat[7:0]));
          chk("a_we_off", 64'(A_write_en), 64'(0));
        end
      end else begin
        chk("we_idle", 64'({A_write_en, B_write_en}), 64'(0));
      end
      pend = S_AXIS_TVALID && S_AXIS_TREADY;
      if (pend) begin
        pend_idx = acc_cnt;
        pend_dat = S_AXIS_TDATA;
        acc_cnt  = (acc_cnt == NA + NB - 1) ? 0 : acc_cnt + 1;
      end
    end
  end

  // Output stall rule: while TVALID=1 and TREADY=0, nothing may change.
  logic        pv, pr, pl;
  logic [31:0] pd;
  always @(negedge clk) begin
    if (!resetn) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("stall_valid", 64'(M_AXIS_TVALID), 64'(1));
        chk("stall_data",  64'(M_AXIS_TDATA), 64'(pd));
        chk("stall_last",  64'(M_AXIS_TLAST), 64'(pl));
      end
      pv = M_AXIS_TVALID;
      pr = M_AXIS_TREADY;
      pd = M_AXIS_TDATA;
      pl = M_AXIS_TLAST;
    end
  end

  task automatic check_reset_outputs();
    chk("rst_s_tready", 64'(S_AXIS_TREADY), 64'(0));
    chk("rst_m_tvalid", 64'(M_AXIS_TVALID), 64'(0));
    chk("rst_m_tdata",  64'(M_AXIS_TDATA), 64'(0));
    chk("rst_m_tlast",  64'(M_AXIS_TLAST), 64'(0));
    chk("rst_a",  64'({A_write_en, A_write_address, A_write_data_in}), 64'(0));
    chk("rst_b",  64'({B_write_en, B_write_address, B_write_data_in}), 64'(0));
    chk("rst_start", 64'(Start), 64'(0));
    chk("rst_res",   64'({RES_read_en, RES_read_address}), 64'(0));
    chk("rst_perf",  64'(compute_cycles), 64'(0));
  endtask

  // Returns #1 after the posedge carrying the last handshake.
  task automatic send_frame(input int nwords, input bit gaps, input bit ramp);
    @(posedge clk); #1;
    for (int k = 0; k < nwords; k++) begin
      logic [31:0] w;
      int t;
      if (gaps && $urandom_range(0, 3) == 0) begin
        S_AXIS_TVALID = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      w = $urandom();
      if (ramp) w[7:0] = k[7:0];
      S_AXIS_TVALID = 1'b1;
      S_AXIS_TDATA  = w;
      S_AXIS_TLAST  = 1'($urandom_range(0, 1));
      t = 0;
      @(negedge clk);
      while (!S_AXIS_TREADY && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) chk("in_ready_timeout", 64'(t), 64'(0));
      @(posedge clk); #1;
    end
    S_AXIS_TVALID = 1'b0;
  endtask

  // Engine model: Done is sampled exactly 'hold' cycles after Start rises.
  task automatic run_engine(input int hold);
    @(negedge clk);
    chk("start_before", 64'(Start), 64'(0));
    @(negedge clk);
    chk("start_rise", 64'(Start), 64'(1));
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      chk("start_held", 64'(Start), 64'(1));
    end
    Done = 1'b1;
    @(posedge clk); #1;
    Done = 1'b0;
    @(negedge clk);
    chk("start_drop", 64'(Start), 64'(0));
    chk("drain_no_read", 64'(RES_read_en), 64'(0));
    @(negedge clk);
    chk("first_read", 64'({RES_read_en, RES_read_address}), 64'({1'b1, 9'd0}));
    @(negedge clk);
    chk("wait_novalid", 64'({M_AXIS_TVALID, RES_read_en}), 64'(0));
    @(negedge clk);
    chk("first_valid", 64'(M_AXIS_TVALID), 64'(1));
`ifdef MM_STREAM_PERF_CNT_EN
    chk("perf_cycles", 64'(compute_cycles), 64'(hold));
`else
    chk("perf_cycles", 64'(compute_cycles), 64'(0));
`endif
  endtask

  // Entered at the negedge where beat 0 is valid.
  task automatic readout(input bit rand_stall);
    for (int b = 0; b < NR; b++) begin
      int t;
      int stall;
      if (b > 0) begin
        t = 0;
        @(negedge clk);
        while (!M_AXIS_TVALID && t < 20) begin
          @(negedge clk);
          t++;
        end
        chk("beat_gap", 64'(t), 64'(1));
      end
      chk("out_data", 64'(M_AXIS_TDATA), 64'(res_mem[b]));
      chk("out_last", 64'(M_AXIS_TLAST), 64'(b == NR - 1));
      stall = rand_stall ? int'($urandom_range(0, 2)) : ((b == 10) ? 7 : 0);
      if (stall > 0) begin
        M_AXIS_TREADY = 1'b0;
        repeat (stall) begin
          @(negedge clk);
          chk("bp_data", 64'({M_AXIS_TVALID, M_AXIS_TDATA}), 64'({1'b1, 24'd0, res_mem[b]}));
        end
        M_AXIS_TREADY = 1'b1;
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("valid_drop", 64'(M_AXIS_TVALID), 64'(0));
    end
    chk("idle_tready", 64'(S_AXIS_TREADY), 64'(0));
    @(negedge clk);
    chk("recv_tready", 64'(S_AXIS_TREADY), 64'(1));
  endtask

  initial begin
    resetn        = 1'b0;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TDATA  = '0;
    S_AXIS_TLAST  = 1'b0;
    M_AXIS_TREADY = 1'b1;
    Done          = 1'b0;
    for (int r = 0; r < 512; r++) res_mem[r] = r[7:0];

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", 64'(S_AXIS_TREADY), 64'(0));
    @(negedge clk);
    chk("recv_a_ready", 64'(S_AXIS_TREADY), 64'(1));

    // Frame 1: ramp data, no gaps, 100-cycle engine run, fixed backpressure.
    send_frame(NA + NB, 1'b0, 1'b1);
    run_engine(100);
    readout(1'b0);

    // Frame 2: random data, reset after 300 words, then a complete frame.
    for (int r = 0; r < 512; r++) res_mem[r] = 8'($urandom());
    send_frame(300, 1'b1, 1'b0);
    resetn = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    resetn = 1'b1;
    send_frame(NA + NB, 1'b1, 1'b0);
    run_engine(37);
    readout(1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    chk("watchdog_expired", 64'(0), 64'(1));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
